// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch time-keeping core.
package stopwatch_pkg;

   localparam int unsigned DIGIT_W = 4;
   localparam int unsigned SEC_MAX = 59;

   typedef logic [DIGIT_W-1:0] digit_t;

   // Adjust field select encoding on the sel input.
   typedef enum logic {
      SEL_MIN = 1'b0,
      SEL_SEC = 1'b1
   } sel_e;

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD counter that wraps from MAX to 00 and flags the wrap.
module bcd2_counter
   import stopwatch_pkg::*;
#(
   parameter int unsigned MAX = 59
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   inc,
   output digit_t ones,
   output digit_t tens,
   output logic   carry
);

   localparam digit_t MAX_ONES = digit_t'(MAX % 10);
   localparam digit_t MAX_TENS = digit_t'(MAX / 10);

   logic at_max;

   assign at_max = (ones == MAX_ONES) && (tens == MAX_TENS);
   // carry is combinational so the next field can step on the same edge
   assign carry  = inc && at_max;

   // Digit registers: wrap to 00 at MAX, otherwise ones 0..9 with carry into tens.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ones <= '0;
         tens <= '0;
      end else if (inc) begin
         if (at_max) begin
            ones <= '0;
            tens <= '0;
         end else if (ones == digit_t'(9)) begin
            ones <= '0;
            tens <= tens + digit_t'(1);
         end else begin
            ones <= ones + digit_t'(1);
         end
      end
   end

endmodule

// File: rtl/stopwatch_counter.sv
// MM:SS stopwatch core: pause state, run/adjust increment muxing, wrap pulse.
module stopwatch_counter
   import stopwatch_pkg::*;
#(
   parameter int unsigned MIN_MAX = 59
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   tick_1hz,
   input  logic   tick_adj,
   input  logic   adj,
   input  logic   sel,
   input  logic   pse,
   output digit_t sec_one,
   output digit_t sec_ten,
   output digit_t min_one,
   output digit_t min_ten,
   output logic   paused,
   output logic   wrap
);

   logic sec_inc;
   logic min_inc;
   logic sec_carry;
   logic min_carry;

   // Increment steering: run mode counts gated 1 Hz ticks with seconds carry,
   // adjust mode steps only the selected field and never carries.
   always_comb begin
      sec_inc = 1'b0;
      min_inc = 1'b0;
      if (adj) begin
         sec_inc = tick_adj && (sel == SEL_SEC);
         min_inc = tick_adj && (sel == SEL_MIN);
      end else begin
         sec_inc = tick_1hz && !paused;
         min_inc = sec_carry;
      end
   end

   bcd2_counter #(.MAX(SEC_MAX)) u_sec (
      .clk   (clk),
      .rst   (rst),
      .inc   (sec_inc),
      .ones  (sec_one),
      .tens  (sec_ten),
      .carry (sec_carry)
   );

   bcd2_counter #(.MAX(MIN_MAX)) u_min (
      .clk   (clk),
      .rst   (rst),
      .inc   (min_inc),
      .ones  (min_one),
      .tens  (min_ten),
      .carry (min_carry)
   );

   // Pause toggles on each pse pulse; wrap pulses only on a run-mode rollover.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         paused <= 1'b0;
         wrap   <= 1'b0;
      end else begin
         paused <= paused ^ pse;
         wrap   <= !adj && min_carry;
      end
   end

endmodule

// File: tb/tb_stopwatch_counter.sv
// Self-checking bench for stopwatch_counter (MIN_MAX=59 and MIN_MAX=9 instances).
module tb_stopwatch_counter;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic tick_1hz = 1'b0;
   logic tick_adj = 1'b0;
   logic adj = 1'b0;
   logic sel = 1'b0;
   logic pse = 1'b0;

   logic [3:0] a_sec_one, a_sec_ten, a_min_one, a_min_ten;
   logic       a_paused, a_wrap;
   logic [3:0] b_sec_one, b_sec_ten, b_min_one, b_min_ten;
   logic       b_paused, b_wrap;

   logic [17:0] act_a, act_b;
   assign act_a = {a_min_ten, a_min_one, a_sec_ten, a_sec_one, a_paused, a_wrap};
   assign act_b = {b_min_ten, b_min_one, b_sec_ten, b_sec_one, b_paused, b_wrap};

   always #5 clk = ~clk;

   stopwatch_counter #(.MIN_MAX(59)) dut_a (
      .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_adj(tick_adj),
      .adj(adj), .sel(sel), .pse(pse),
      .sec_one(a_sec_one), .sec_ten(a_sec_ten), .min_one(a_min_one), .min_ten(a_min_ten),
      .paused(a_paused), .wrap(a_wrap)
   );

   stopwatch_counter #(.MIN_MAX(9)) dut_b (
      .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_adj(tick_adj),
      .adj(adj), .sel(sel), .pse(pse),
      .sec_one(b_sec_one), .sec_ten(b_sec_ten), .min_one(b_min_one), .min_ten(b_min_ten),
      .paused(b_paused), .wrap(b_wrap)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: time as minutes/seconds integers.
   typedef struct {
      int mm;
      int ss;
      bit paused;
      bit wrap;
   } mstate_t;

   mstate_t ma, mb;

   function automatic mstate_t model_next(mstate_t s, bit t1, bit ta, bit a, bit sl,
                                          bit p, int mmax);
      mstate_t n;
      int total;
      n = s;
      n.wrap = 1'b0;
      if (!a) begin
         if (t1 && !s.paused) begin
            total = s.mm * 60 + s.ss + 1;
            if (total == (mmax + 1) * 60) begin
               total  = 0;
               n.wrap = 1'b1;
            end
            n.mm = total / 60;
            n.ss = total % 60;
         end
      end else if (ta) begin
         if (sl) n.ss = (s.ss + 1) % 60;
         else    n.mm = (s.mm + 1) % (mmax + 1);
      end
      n.paused = s.paused ^ p;
      return n;
   endfunction

   function automatic logic [17:0] vec(int mm, int ss, bit p, bit w);
      return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), p, w};
   endfunction

   function automatic logic [17:0] exp_vec(mstate_t s);
      return vec(s.mm, s.ss, s.paused, s.wrap);
   endfunction

   task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h (mm %0d%0d ss %0d%0d p %0b w %0b), expected %h",
                  name, act, act[17:14], act[13:10], act[9:6], act[5:2], act[1], act[0], exp);
      end
   endtask

   function automatic mstate_t model_reset();
      mstate_t s;
      s.mm = 0; s.ss = 0; s.paused = 1'b0; s.wrap = 1'b0;
      return s;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      tick_1hz = 1'b0; tick_adj = 1'b0; pse = 1'b0; adj = 1'b0; sel = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      ma = model_reset();
      mb = model_reset();
      check("reset_a", act_a, 18'd0);
      check("reset_b", act_b, 18'd0);
   endtask

   // One clock: inputs applied at negedge, model stepped at posedge, compared 1 time unit later.
   task automatic cycle(input bit t1, input bit ta, input bit a, input bit sl, input bit p);
      @(negedge clk);
      tick_1hz = t1; tick_adj = ta; adj = a; sel = sl; pse = p;
      @(posedge clk);
      ma = model_next(ma, t1, ta, a, sl, p, 59);
      mb = model_next(mb, t1, ta, a, sl, p, 9);
      #1;
      check("model_a", act_a, exp_vec(ma));
      check("model_b", act_b, exp_vec(mb));
      tick_1hz = 1'b0; tick_adj = 1'b0; pse = 1'b0;
   endtask

   typedef struct {
      bit t1, ta, a, sl, p;
      int mm, ss;
      bit ep, ew;
   } vec_t;

   vec_t tbl[12];
   bit   saw_wrap;

   initial begin
      // t1 ta adj sel pse | mm ss paused wrap
      tbl[0]  = '{1, 0, 0, 0, 0, 0, 1, 0, 0};
      tbl[1]  = '{1, 0, 0, 0, 0, 0, 2, 0, 0};
      tbl[2]  = '{1, 0, 0, 0, 1, 0, 3, 1, 0};
      tbl[3]  = '{1, 0, 0, 0, 0, 0, 3, 1, 0};
      tbl[4]  = '{0, 1, 1, 1, 0, 0, 4, 1, 0};
      tbl[5]  = '{0, 1, 1, 0, 0, 1, 4, 1, 0};
      tbl[6]  = '{1, 0, 1, 0, 0, 1, 4, 1, 0};
      tbl[7]  = '{0, 1, 0, 0, 0, 1, 4, 1, 0};
      tbl[8]  = '{0, 0, 0, 0, 1, 1, 4, 0, 0};
      tbl[9]  = '{1, 1, 0, 0, 0, 1, 5, 0, 0};
      tbl[10] = '{1, 1, 1, 1, 0, 1, 6, 0, 0};
      tbl[11] = '{1, 0, 0, 0, 0, 1, 7, 0, 0};

      do_reset();
      for (int i = 0; i < 12; i++) begin
         cycle(tbl[i].t1, tbl[i].ta, tbl[i].a, tbl[i].sl, tbl[i].p);
         check($sformatf("table_%0d", i), act_a, vec(tbl[i].mm, tbl[i].ss, tbl[i].ep, tbl[i].ew));
      end

      // Reset then 75 run ticks.
      do_reset();
      saw_wrap = 1'b0;
      for (int i = 0; i < 75; i++) begin
         cycle(1, 0, 0, 0, 0);
         saw_wrap |= a_wrap;
      end
      check("run_75", act_a, vec(1, 15, 0, 0));
      check("run_75_nowrap", {17'd0, saw_wrap}, 18'd0);

      // Rollover from 59:58 (09:58 on the MIN_MAX=9 instance).
      do_reset();
      for (int i = 0; i < 59; i++) cycle(0, 1, 1, 0, 0);
      for (int i = 0; i < 58; i++) cycle(0, 1, 1, 1, 0);
      check("preload_5958", act_a, vec(59, 58, 0, 0));
      cycle(1, 0, 0, 0, 0);
      check("roll_5959", act_a, vec(59, 59, 0, 0));
      cycle(1, 0, 0, 0, 0);
      check("roll_0000_a", act_a, vec(0, 0, 0, 1));
      check("roll_0000_b", act_b, vec(0, 0, 0, 1));
      cycle(0, 0, 0, 0, 0);
      check("roll_wrap_drop", act_a, vec(0, 0, 0, 0));

      // Pause behaviour.
      do_reset();
      for (int i = 0; i < 10; i++) cycle(1, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 1);
      for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, 0);
      check("pause_hold", act_a, vec(0, 10, 1, 0));
      cycle(0, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0);
      check("pause_resume", act_a, vec(0, 13, 0, 0));
      cycle(1, 0, 0, 0, 1);
      check("pause_same_cycle", act_a, vec(0, 14, 1, 0));

      // Adjust seconds across 59 with 1 Hz ticks present.
      do_reset();
      for (int i = 0; i < 58; i++) cycle(1, 0, 0, 0, 0);
      cycle(1, 1, 1, 1, 0);
      check("adj_sec_59", act_a, vec(0, 59, 0, 0));
      cycle(1, 1, 1, 1, 0);
      check("adj_sec_00", act_a, vec(0, 0, 0, 0));
      cycle(1, 1, 1, 1, 0);
      check("adj_sec_01", act_a, vec(0, 1, 0, 0));

      // Adjust minutes across MIN_MAX.
      do_reset();
      for (int i = 0; i < 58; i++) cycle(0, 1, 1, 0, 0);
      for (int i = 0; i < 30; i++) cycle(0, 1, 1, 1, 0);
      cycle(0, 1, 1, 0, 0);
      check("adj_min_59", act_a, vec(59, 30, 0, 0));
      cycle(0, 1, 1, 0, 0);
      check("adj_min_00", act_a, vec(0, 30, 0, 0));

      // MIN_MAX=9 minute adjust wrap.
      do_reset();
      for (int i = 0; i < 9; i++) cycle(0, 1, 1, 0, 0);
      check("adj9_0900", act_b, vec(9, 0, 0, 0));
      cycle(0, 1, 1, 0, 0);
      check("adj9_0000", act_b, vec(0, 0, 0, 0));

      // Asynchronous reset between edges at 12:34 paused.
      do_reset();
      for (int i = 0; i < 12; i++) cycle(0, 1, 1, 0, 0);
      for (int i = 0; i < 34; i++) cycle(0, 1, 1, 1, 0);
      cycle(0, 0, 0, 0, 1);
      check("pre_async", act_a, vec(12, 34, 1, 0));
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("async_clear_a", act_a, 18'd0);
      check("async_clear_b", act_b, 18'd0);
      @(negedge clk);
      rst = 1'b0;
      ma = model_reset();
      mb = model_reset();
      cycle(1, 0, 0, 0, 0);
      check("after_async", act_a, vec(0, 1, 0, 0));

      // Randomized stimulus against the model.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         bit a_lvl, s_lvl;
         a_lvl = ($urandom_range(0, 15) == 0) ? ~adj : adj;
         s_lvl = ($urandom_range(0, 7) == 0) ? ~sel : sel;
         cycle($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 4, a_lvl, s_lvl,
               $urandom_range(0, 19) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
